// File: rtl/dram_pkg.sv
// Shared definitions for the burst DRAM model: default geometry, FSM encoding
// and the memory-map region bases used by the accelerator benches.
package dram_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 18;

   localparam int IMAGE_BASE = 0;
   localparam int POOL_BASE  = 65536;
   localparam int CONV_BASE  = 131072;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_t;

endpackage

// File: rtl/dram_array.sv
// 1W1R synchronous storage with a registered read port; a read colliding with a
// write to the same address at the same edge returns the previous contents.
module dram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   // Both updates are non-blocking, so a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/dram_burst.sv
// Off-chip DRAM model with programmable read latency and multi-beat burst reads
// from consecutive (wrapping) addresses; the write port is single-cycle.
module dram_burst
   import dram_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int RD_LATENCY  = 2,
   parameter int BURST_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   srstn,
   input  logic                   en_wr,
   input  logic [ADDR_WIDTH-1:0]  addr_wr,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   en_rd,
   input  logic [ADDR_WIDTH-1:0]  addr_rd,
   input  logic [BURST_WIDTH-1:0] burst_len,
   output logic                   rd_busy,
   output logic                   valid,
   output logic                   last,
   output logic [DATA_WIDTH-1:0]  data_out
);

   localparam int               LAT_W    = 5;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

   if (RD_LATENCY < 1 || RD_LATENCY > 16) begin : g_bad_latency
      $error("dram_burst: RD_LATENCY must lie in 1..16");
   end

   state_t                 state;
   logic [LAT_W-1:0]       lat_cnt;
   logic [BURST_WIDTH-1:0] beat_cnt;
   logic [BURST_WIDTH-1:0] len;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   accept;
   logic                   rd_en;

   assign accept = (state == IDLE) && en_rd && !rd_busy;
   assign rd_en  = (state == BURST);

   // Control path: FSM, counters and the registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         beat_cnt <= '0;
         rd_busy  <= 1'b0;
         valid    <= 1'b0;
         last     <= 1'b0;
      end else begin
         valid <= 1'b0;
         last  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_cnt  <= LAT_LOAD;
                  beat_cnt <= '0;
                  rd_busy  <= 1'b1;
                  state    <= (RD_LATENCY == 1) ? BURST : WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt == LAT_W'(1)) begin
                  state <= BURST;
               end
            end
            BURST: begin
               valid <= 1'b1;
               if (beat_cnt == len) begin
                  last    <= 1'b1;
                  rd_busy <= 1'b0;
                  state   <= IDLE;
               end else begin
                  beat_cnt <= beat_cnt + BURST_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Data path: request capture and the wrapping read address.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr <= addr_rd;
         len  <= burst_len;
      end else if (state == BURST) begin
         addr <= addr + ADDR_WIDTH'(1);
      end
   end

   dram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (en_wr),
      .wr_addr (addr_wr),
      .wr_data (data_in),
      .rd_en   (rd_en),
      .rd_addr (addr),
      .rd_data (rd_data)
   );

   // The array output carries no reset, so it is qualified by valid.
   assign data_out = valid ? rd_data : '0;

endmodule

// File: tb/tb_dram_burst.sv
// Directed bench for dram_burst: latency-1 single beat, table of latency-4 bursts,
// then collision, busy-drop, back-to-back and mid-burst reset sequences.
module tb_dram_burst;

   localparam int DW = 32;
   localparam int AW = 18;
   localparam int BW = 4;
   localparam int LB = 4;

   logic clk = 1'b0;
   logic srstn;

   logic          en_wr, en_rd, rd_busy, valid, last;
   logic [AW-1:0] addr_wr, addr_rd;
   logic [DW-1:0] data_in, data_out;
   logic [BW-1:0] burst_len;

   logic          a_en_wr, a_en_rd, a_rd_busy, a_valid, a_last;
   logic [AW-1:0] a_addr_wr, a_addr_rd;
   logic [DW-1:0] a_data_in, a_data_out;
   logic [BW-1:0] a_burst_len;

   logic [31:0] shadow [0:(1<<AW)-1];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [BW-1:0] len;
      logic [31:0]   first_v;
      logic [31:0]   last_v;
   } vec_t;
   vec_t tbl [5];

   always #5 clk = ~clk;

   dram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .BURST_WIDTH(BW)) dut_a (
      .clk(clk), .srstn(srstn), .en_wr(a_en_wr), .addr_wr(a_addr_wr), .data_in(a_data_in),
      .en_rd(a_en_rd), .addr_rd(a_addr_rd), .burst_len(a_burst_len), .rd_busy(a_rd_busy),
      .valid(a_valid), .last(a_last), .data_out(a_data_out));

   dram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LB), .BURST_WIDTH(BW)) dut_b (
      .clk(clk), .srstn(srstn), .en_wr(en_wr), .addr_wr(addr_wr), .data_in(data_in),
      .en_rd(en_rd), .addr_rd(addr_rd), .burst_len(burst_len), .rd_busy(rd_busy),
      .valid(valid), .last(last), .data_out(data_out));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         dut_b.u_array.mem[a] = 32'(a);
         shadow[a] = 32'(a);
      end
   endtask

   task automatic req(input logic [AW-1:0] a, input logic [BW-1:0] n);
      en_rd     = 1'b1;
      addr_rd   = a;
      burst_len = n;
   endtask

   // The request must already be on the bus; the first step is the accept edge.
   task automatic run_burst(input logic [AW-1:0] a, input logic [BW-1:0] n,
                            input int wr_beat, input logic [31:0] wr_val, input bit drop,
                            input bit chain, input logic [AW-1:0] ca, input logic [BW-1:0] cn,
                            input int rst_beat, output logic [31:0] first_d,
                            output logic [31:0] last_d);
      logic [AW-1:0] ba;
      first_d = '0;
      last_d  = '0;
      step;
      chk("busy_after_accept", 32'(rd_busy), 32'd1);
      chk("no_valid_at_accept", 32'(valid), 32'd0);
      if (drop) begin
         addr_rd   = 18'h3FF00;
         burst_len = 4'd5;
      end else begin
         en_rd = 1'b0;
      end
      for (int k = 1; k < LB; k++) begin
         step;
         en_rd = 1'b0;
         chk("wait_no_valid", 32'(valid), 32'd0);
      end
      for (int i = 0; i <= int'(n); i++) begin
         ba = a + AW'(i);
         if (i == wr_beat) begin
            en_wr   = 1'b1;
            addr_wr = ba;
            data_in = wr_val;
         end
         step;
         en_rd = 1'b0;
         chk("beat_valid", 32'(valid), 32'd1);
         chk("beat_data", data_out, shadow[ba]);
         chk("beat_last", 32'(last), 32'(i == int'(n)));
         chk("beat_busy", 32'(rd_busy), 32'(i != int'(n)));
         if (en_wr) begin
            shadow[addr_wr] = data_in;
            en_wr = 1'b0;
         end
         if (i == 0) first_d = data_out;
         last_d = data_out;
         if (i == rst_beat) begin
            srstn = 1'b0;
            step;
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_last", 32'(last), 32'd0);
            chk("rst_data", data_out, 32'd0);
            chk("rst_busy", 32'(rd_busy), 32'd0);
            return;
         end
      end
      if (chain) req(ca, cn);
   endtask

   initial begin
      logic [31:0] f, l;
      int extra;

      tbl[0] = '{18'h00100, 4'd15, 32'h00000100, 32'h0000010F};
      tbl[1] = '{18'h3FFFE, 4'd3,  32'h0003FFFE, 32'h00000001};
      tbl[2] = '{18'h00020, 4'd0,  32'h00000020, 32'h00000020};
      tbl[3] = '{18'h3FFF0, 4'd15, 32'h0003FFF0, 32'h0003FFFF};
      tbl[4] = '{18'h00005, 4'd2,  32'h00000005, 32'h00000007};

      srstn = 1'b0;
      en_wr = 0; en_rd = 0; addr_wr = '0; addr_rd = '0; data_in = '0; burst_len = '0;
      a_en_wr = 0; a_en_rd = 0; a_addr_wr = '0; a_addr_rd = '0; a_data_in = '0; a_burst_len = '0;
      load(0, 16'h07FF);
      load(18'h3FF00, 18'h3FFFF);

      repeat (3) step;
      chk("rst_b_valid", 32'(valid), 32'd0);
      chk("rst_b_last", 32'(last), 32'd0);
      chk("rst_b_data", data_out, 32'd0);
      chk("rst_b_busy", 32'(rd_busy), 32'd0);
      chk("rst_a_valid", 32'(a_valid), 32'd0);
      chk("rst_a_data", a_data_out, 32'd0);
      chk("rst_a_busy", 32'(a_rd_busy), 32'd0);
      srstn = 1'b1;
      step;

      // Single beat through the write port, latency 1.
      a_en_wr = 1'b1; a_addr_wr = 18'h00010; a_data_in = 32'hDEADBEEF;
      step;
      a_en_wr = 1'b0;
      chk("a_backdoor", dut_a.u_array.mem[18'h00010], 32'hDEADBEEF);
      a_en_rd = 1'b1; a_addr_rd = 18'h00010; a_burst_len = 4'd0;
      step;
      a_en_rd = 1'b0;
      chk("a_accept_busy", 32'(a_rd_busy), 32'd1);
      chk("a_accept_valid", 32'(a_valid), 32'd0);
      step;
      chk("a_beat_valid", 32'(a_valid), 32'd1);
      chk("a_beat_last", 32'(a_last), 32'd1);
      chk("a_beat_data", a_data_out, 32'hDEADBEEF);
      chk("a_beat_busy", 32'(a_rd_busy), 32'd0);
      step;
      chk("a_after_valid", 32'(a_valid), 32'd0);

      for (int r = 0; r < 5; r++) begin
         req(tbl[r].addr, tbl[r].len);
         run_burst(tbl[r].addr, tbl[r].len, -1, '0, 1'b0, 1'b0, '0, '0, -1, f, l);
         chk("tbl_first", f, tbl[r].first_v);
         chk("tbl_last", l, tbl[r].last_v);
         step;
         chk("tbl_idle_valid", 32'(valid), 32'd0);
      end

      // Same-edge write to the address being read returns the old word.
      req(18'h00200, 4'd3);
      run_burst(18'h00200, 4'd3, 1, 32'h55, 1'b0, 1'b0, '0, '0, -1, f, l);
      step;
      req(18'h00201, 4'd0);
      run_burst(18'h00201, 4'd0, -1, '0, 1'b0, 1'b0, '0, '0, -1, f, l);
      chk("collision_reread", f, 32'h00000055);
      step;

      // A request while busy is dropped.
      req(18'h00300, 4'd3);
      run_burst(18'h00300, 4'd3, -1, '0, 1'b1, 1'b0, '0, '0, -1, f, l);
      extra = 0;
      for (int k = 0; k < LB + 6; k++) begin
         step;
         if (valid) extra++;
      end
      chk("drop_no_extra", 32'(extra), 32'd0);

      // Request in the last cycle is accepted at the next edge.
      req(18'h00400, 4'd1);
      run_burst(18'h00400, 4'd1, -1, '0, 1'b0, 1'b1, 18'h00500, 4'd0, -1, f, l);
      run_burst(18'h00500, 4'd0, -1, '0, 1'b0, 1'b0, '0, '0, -1, f, l);
      chk("chain_data", f, 32'h00000500);
      step;
      chk("chain_idle", 32'(valid), 32'd0);

      // Reset aborts a burst but leaves memory intact.
      req(18'h00600, 4'd7);
      run_burst(18'h00600, 4'd7, -1, '0, 1'b0, 1'b0, '0, '0, 3, f, l);
      step;
      srstn = 1'b1;
      extra = 0;
      for (int k = 0; k < 10; k++) begin
         step;
         if (valid) extra++;
      end
      chk("rst_abort_no_beats", 32'(extra), 32'd0);
      chk("rst_backdoor", dut_b.u_array.mem[18'h00603], 32'h00000603);
      req(18'h00600, 4'd7);
      run_burst(18'h00600, 4'd7, -1, '0, 1'b0, 1'b0, '0, '0, -1, f, l);
      chk("rst_reread_last", l, 32'h00000607);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dram_burst.md
# dram_burst

Parametrised successor to the team's single-beat DRAM model, used by the LeNet accelerator benches and the CHIP post-layout sims as the off-chip memory. It adds two things the single-beat model lacks: a programmable read latency and multi-beat burst reads from consecutive addresses. It keeps the existing single-cycle write port unchanged. It sits between the accelerator's `dram_en_rd`/`dram_addr_rd`/`dram_en_wr` bus and the bench's pattern loaders.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 18, word address width; depth = 2**ADDR_WIDTH.
- `RD_LATENCY`, 2, edges from request acceptance to first `valid`; legal range 1..16.
- `BURST_WIDTH`, 4, width of `burst_len`; maximum burst = 2**BURST_WIDTH beats.

- `clk` in 1: single clock, rising edge.
- `srstn` in 1: synchronous, active-low reset.
- `en_wr` in 1: write strobe.
- `addr_wr` in ADDR_WIDTH: write address.
- `data_in` in DATA_WIDTH: write data.
- `en_rd` in 1: read request.
- `addr_rd` in ADDR_WIDTH: burst start address.
- `burst_len` in BURST_WIDTH: number of beats minus 1.
- `rd_busy` out 1: high while a burst is in progress; requests made while it is high are ignored.
- `valid` out 1: `data_out` holds a beat.
- `last` out 1: marks the final beat of a burst.
- `data_out` out DATA_WIDTH: read data.

## Operation
- FSM states: IDLE, WAIT, BURST.
- **IDLE**
  - A request is accepted at an edge where `en_rd`=1 and `rd_busy`=0.
  - On acceptance, latch `addr_rd` and `burst_len`, load the latency counter with RD_LATENCY-1, and go to WAIT.
  - If RD_LATENCY=1, go directly to BURST.
- **WAIT**
  - Decrement the latency counter each edge.
  - At zero, go to BURST.
- **BURST**
  - Each edge reads one word at the current address into the `data_out` register and sets `valid`=1.
  - The address increments modulo 2**ADDR_WIDTH, so 0x3FFFF is followed by 0x00000.
  - The beat counter counts up to `burst_len`.
  - The beat with count == `burst_len` also sets `last`=1; the FSM then returns to IDLE.
- **Writes**
  - `en_wr` writes `data_in` to `addr_wr` at any edge, in any state, independent of reads.
- **Read/write ordering**
  - A beat read at edge E returns the write data from edges before E.
  - A write to the same address at edge E itself is not visible to that beat; the beat returns the old data.
- **Reset**
  - Reset values: `valid`=0, `last`=0, `data_out`=0, `rd_busy`=0; FSM goes to IDLE and counters clear.
  - Memory contents are not cleared.
  - Reset in the middle of a burst aborts it: no further beats.
- An `en_rd` pulse that arrives while `rd_busy`=1 is dropped silently; it is not queued.

## Timing
- With a request accepted at edge E0:
  - beat i is valid in the cycle following edge E0+RD_LATENCY+i, for i = 0..`burst_len`.
  - `rd_busy` rises after E0 and falls after edge E0+RD_LATENCY+`burst_len`, i.e. it is 0 during the cycle in which `last`=1.
- Back-to-back bursts: a new request can be accepted at the edge that closes the `last` cycle. Its first beat follows RD_LATENCY edges later.
- `valid` and `last` are high for exactly one cycle per beat. There is no back-pressure: the consumer must take each beat.
- `burst_len`=0 gives a single-beat read. With RD_LATENCY=1 this matches the single-beat model's timing.

## Structure
- Package `dram_pkg`:
  - default DATA_WIDTH and ADDR_WIDTH;
  - FSM state enum (IDLE/WAIT/BURST, 2 bits);
  - region base addresses shared by the benches: 0 for the image, 65536 for pooled output, 131072 for conv output.
- Sub-module `dram_array`: 1W1R synchronous array with a registered read port. It has no reset, and reads return old data on a same-address collision.
- `dram_burst` itself holds the FSM, the latency counter, the beat counter and the address register.
- Bench back-door load and check tasks hierarchically reference `dram_array.mem`.

## Test plan
- **Single beat:** RD_LATENCY=1, write 0xDEADBEEF to 0x00010, then read 0x00010 with `burst_len`=0 → one beat 0xDEADBEEF with `valid`=`last`=1, one cycle after acceptance.
- **Burst with latency:** RD_LATENCY=4, `burst_len`=15, start 0x00100, with mem[a]=a preloaded → beats 0x100..0x10F on 16 consecutive cycles, the first 4 edges after acceptance; `last` only on 0x10F.
- **Wrap-around:** start 0x3FFFE, `burst_len`=3 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- **Collision:** a write of 0x55 to the address being read at the same edge → the beat returns old data; a re-read returns 0x55.
- **Busy drop:** a second `en_rd` while `rd_busy`=1 → ignored, with no extra beats. A request issued in the `last` cycle → accepted, and its first beat follows RD_LATENCY edges later.
- **Reset mid-burst:** `srstn`=0 during beat 3 of 8 → `valid`, `last`, `data_out` and `rd_busy` are 0 on the next cycle; after release, memory still reads back its pre-reset contents.
